// File: rtl/demux_dispatch_if.sv
// demux_dispatch_if: request handshake and demux drive bus for demux_dispatch
interface demux_dispatch_if #(parameter int DEPTH = 4);
  logic in_valid;
  logic in_ready;
  logic [2:0] in_dest;
  logic in_bit;
  logic [2:0] sel;
  logic a_out;
  logic out_active;
  logic [$clog2(DEPTH):0] count;
  logic busy;
  modport master (output in_valid, in_dest, in_bit, input in_ready, sel, a_out, out_active, count, busy);
  modport slave (input in_valid, in_dest, in_bit, output in_ready, sel, a_out, out_active, count, busy);
endinterface

// File: rtl/demux_dispatch.sv
// demux_dispatch: FIFO-buffered requests, each driven onto a 1-to-8 demux for HOLD cycles then a gap
module demux_dispatch #(
  parameter int DEPTH = 4,
  parameter int HOLD = 2
) (
  input logic clk,
  input logic rst,
  demux_dispatch_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
  state_t state, state_d;
  logic [3:0] mem [DEPTH];
  logic [3:0] head;
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [3:0] hold, hold_d;
  logic [2:0] sel_d;
  logic a_d, act_d, push, pop, done;
  assign bus.in_ready = cnt != CW'(DEPTH);
  assign bus.count = cnt;
  assign bus.busy = state != IDLE || cnt != '0;
  assign push = bus.in_valid && bus.in_ready;
  // IDLE and GAP both pop whenever anything is queued
  assign pop = state != DRIVE && cnt != '0;
  assign done = state == DRIVE && hold == '0;
  assign head = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= {bus.in_dest, bus.in_bit};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      hold <= '0;
      bus.sel <= '0;
      bus.a_out <= 1'b0;
      bus.out_active <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt + CW'(push) - CW'(pop);
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      hold <= hold_d;
      bus.sel <= sel_d;
      bus.a_out <= a_d;
      bus.out_active <= act_d;
    end
  end
  always_comb
    state_d = pop ? DRIVE : done ? GAP : state == GAP ? IDLE : state;
  always_comb begin
    hold_d = pop ? 4'(HOLD - 1) : (state == DRIVE && !done) ? hold - 4'd1 : hold;
    sel_d = pop ? head[3:1] : bus.sel;
    a_d = pop ? head[0] : done ? 1'b0 : bus.a_out;
    act_d = pop ? 1'b1 : done ? 1'b0 : bus.out_active;
  end
endmodule

// File: tb/tb_demux_dispatch.sv
// tb_demux_dispatch: directed and random stimulus against a start-time schedule model
module tb_demux_dispatch;
  localparam int DEPTH = 4;
  localparam int HOLD = 2;
  logic clk, rst;
  int tests = 0, fails = 0, e = 0, last = -1000;
  int pe[$], st[$];
  logic [2:0] dq[$];
  logic bq[$];
  demux_dispatch_if #(.DEPTH(DEPTH)) bus ();
  demux_dispatch #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  function automatic int mcount(int at);
    int n = 0;
    foreach (pe[i]) if (pe[i] <= at) n++;
    foreach (st[i]) if (st[i] <= at) n--;
    return n;
  endfunction
  task automatic cmp(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s at edge %0d: got %0h expected %0h", tag, e, got, exp);
    end
  endtask
  task automatic check();
    int c = mcount(e);
    logic act = 0, ab = 0, bz;
    logic [2:0] s = 0;
    bz = c != 0;
    foreach (st[i]) begin
      if (st[i] <= e) s = dq[i];
      if (st[i] <= e && e < st[i] + HOLD) begin
        act = 1;
        ab = bq[i];
      end
      if (st[i] <= e && e <= st[i] + HOLD) bz = 1;
    end
    cmp("count", 4'(bus.count), 4'(c));
    cmp("in_ready", 4'(bus.in_ready), 4'(c != DEPTH));
    cmp("out_active", 4'(bus.out_active), 4'(act));
    cmp("a_out", 4'(bus.a_out), 4'(ab));
    cmp("sel", 4'(bus.sel), 4'(s));
    cmp("busy", 4'(bus.busy), 4'(bz));
  endtask
  task automatic step(input logic r, input logic v, input logic [2:0] d, input logic b, output logic acc);
    int s;
    rst = r;
    bus.in_valid = v;
    bus.in_dest = d;
    bus.in_bit = b;
    acc = !r && v && mcount(e) != DEPTH;
    @(posedge clk);
    e++;
    if (r) begin
      pe.delete();
      st.delete();
      dq.delete();
      bq.delete();
      last = -1000;
    end else if (acc) begin
      s = (e + 1 > last + HOLD + 1) ? e + 1 : last + HOLD + 1;
      pe.push_back(e);
      st.push_back(s);
      dq.push_back(d);
      bq.push_back(b);
      last = s;
    end
    #1 check();
  endtask
  initial begin
    logic acc;
    logic [2:0] held [6];
    int base, target, n;
    held = '{3'd0, 3'd7, 3'd4, 3'd6, 3'd2, 3'd3};
    repeat (2) step(1, 1, 3'd5, 1, acc);
    repeat (5) step(0, 0, 0, 0, acc);
    step(0, 1, 3'd1, 1, acc);
    repeat (6) step(0, 0, 0, 0, acc);
    foreach (held[k]) ;
    step(0, 1, 3'd1, 1, acc);
    step(0, 1, 3'd2, 1, acc);
    step(0, 1, 3'd3, 1, acc);
    step(0, 1, 3'd5, 1, acc);
    repeat (14) step(0, 0, 0, 0, acc);
    for (int k = 0; k < 6; k++) begin
      n = 0;
      do begin
        step(0, 1, held[k], k[0], acc);
        n++;
      end while (!acc && n < 50);
      cmp("stall_accept", 4'(acc), 4'd1);
    end
    repeat (25) step(0, 0, 0, 0, acc);
    base = st.size();
    step(0, 1, 3'd4, 1, acc);
    step(0, 1, 3'd5, 0, acc);
    step(0, 1, 3'd6, 1, acc);
    target = st[base + 1];
    while (e < target + 1) step(0, 0, 0, 0, acc);
    cmp("mid_drive", 4'(bus.sel), 4'd5);
    step(1, 1, 3'd7, 1, acc);
    repeat (10) step(0, 0, 0, 0, acc);
    for (int k = 0; k < 500; k++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, 3'($urandom), 1'($urandom), acc);
    repeat (30) step(0, 0, 0, 0, acc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/demux_dispatch.md
DEMUX_DISPATCH -- requirements
Module: demux_dispatch

Interface
REQ-001 Parameter DEPTH, default 4, number of pending-request FIFO entries; power of two, 2..16.
REQ-002 Parameter HOLD, default 2, cycles each request drives the demux; 1..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 in_dest  input  3  destination demux channel, 0..7.
REQ-008 in_bit  input  1  data bit to route to the destination.
REQ-009 sel  output  3  select bus to the 1-to-8 demux.
REQ-010 a_out  output  1  data input to the 1-to-8 demux.
REQ-011 out_active  output  1  high while sel/a_out carry a valid request.
REQ-012 count  output  $clog2(DEPTH)+1  number of queued requests, 0..DEPTH.
REQ-013 busy  output  1  high when state != IDLE or count != 0.

Function
REQ-014 The block SHALL buffer requests in a DEPTH-entry FIFO of {in_dest, in_bit}, storing in arrival order.
REQ-015 in_ready SHALL equal (count != DEPTH), derived combinationally from the registered count only.
REQ-016 A push SHALL occur on an edge where in_valid && in_ready; when in_ready is low, in_valid is ignored and no data is lost or overwritten.
REQ-017 Full case: with count == DEPTH, no push SHALL occur, even on a cycle where a pop occurs.
REQ-018 The FSM SHALL have exactly three states: IDLE, DRIVE and GAP.
REQ-019 IDLE with count > 0: pop the head, load sel/a_out from it, set out_active=1, load the hold counter with HOLD-1, and go to DRIVE.
REQ-020 IDLE with count == 0: remain in IDLE.
REQ-021 DRIVE: hold sel, a_out and out_active=1; when the hold counter is 0, go to GAP with out_active=0 and a_out=0; otherwise decrement the hold counter.
REQ-022 GAP lasts one cycle; sel SHALL retain its last value.
REQ-023 On leaving GAP with count > 0, the block SHALL pop and enter DRIVE directly, exactly as in REQ-019; with count == 0 it SHALL return to IDLE.
REQ-024 count SHALL be +1 on push only, -1 on pop only, and unchanged when a push and a pop occur on the same edge.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 Empty case: a pop SHALL never occur with count == 0.
REQ-027 Latency from a push into an empty, IDLE block to out_active=1 SHALL be 2 edges: push edge, then pop edge.
REQ-028 out_active SHALL be high for exactly HOLD consecutive cycles per request, followed by at least 1 low cycle.
REQ-029 sel, a_out and out_active SHALL be registered outputs.

Reset
REQ-030 rst high at an edge SHALL force: state=IDLE, count=0, pointers=0, hold counter=0, sel=0, a_out=0, out_active=0.
REQ-031 Reset SHALL take priority over any simultaneous push or pop.
REQ-032 Reset mid-DRIVE SHALL discard the active request and all queued requests.
REQ-033 in_ready SHALL be 1 during the first cycle after reset.

Verification
REQ-034 Reset then idle 5 cycles -> sel=0, a_out=0, out_active=0, count=0, in_ready=1, busy=0 throughout.
REQ-035 Push {dest=1, bit=1} into the empty block (HOLD=2) -> out_active high for cycles 2-3 after the push with sel=001 and a_out=1, then GAP, then IDLE with busy=0.
REQ-036 Push dest 1, 2, 3, 5 (bit=1) back-to-back -> count reaches 3 (one entry already popped), sel sequence 001, 010, 011, 101, each held 2 cycles and separated by 1 GAP cycle, and no idle gap beyond GAP.
REQ-037 Push 6 requests with in_valid held high -> in_ready drops when count=4, the stalled requests are accepted as entries drain, and all 6 are delivered in order.
REQ-038 Assert rst during the DRIVE of the 2nd of 3 queued requests -> next cycle out_active=0, count=0, and the 3rd request is never driven.
REQ-039 Push on the same edge that GAP pops -> count unchanged on that edge, and the entry is delivered after the current queue contents.
